data_sram_responder: RTL and testbench

- Responder end of the data SRAM interface driven by the execute stage; models the data memory that satisfies loads and stores.
- Word-organised synchronous RAM with byte write strobes.
- Read data returns through a configurable-latency pipeline.
- Sticky out-of-range error flag.
- Used in simulation top-levels and as the FPGA data-memory wrapper.

---
 rtl/data_sram_responder.sv | 182 ++++++++++++++++++
 tb/tb_data_sram_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Purpose:
//   Responder end of the data SRAM interface driven by the execute stage.
//   Models the data memory that satisfies loads and stores: a word-organised
//   RAM with byte write strobes, whose read results return through a
//   READ_LATENCY-deep pipeline. Every accepted access reads the addressed
//   word before that edge's write (read-before-write). Out-of-range accesses
//   are dropped, return zero and raise a sticky error flag.
//
// Parameters:
//   ADDR_WIDTH    word-index width; the memory holds 2^ADDR_WIDTH 32-bit words
//                 (at most 30)
//   READ_LATENCY  edges from an accepted access to its result on
//                 data_read_data / data_read_valid (1..4)
//
// Ports:
//   clock               in   sole clock, all logic on posedge
//   reset               in   synchronous, active-high
//   data_enabled        in   access request this cycle
//   data_write_enabled  in   [3:0] byte strobes, bit i writes lane [8i+7:8i]
//   data_address        in   [31:0] byte address, bits [1:0] ignored
//   data_write_data     in   [31:0] store data
//   data_read_data      out  [31:0] read result (holds between accesses)
//   data_read_valid     out  one-cycle pulse marking a returned load
//   address_error       out  sticky out-of-range flag, cleared by reset
//
// Optional build macro DATA_SRAM_STATS_EN adds:
//   load_count          out  [31:0] accepted loads (includes out-of-range)
//   store_count         out  [31:0] in-range stores with nonzero strobes
//   error_count         out  [15:0] out-of-range accesses
//   All counters wrap and clear on reset.
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_enabled,
  input  logic [3:0]  data_write_enabled,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write_data,
  output logic [31:0] data_read_data,
  output logic        data_read_valid,
  output logic        address_error
`ifdef DATA_SRAM_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [15:0] error_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LAST  = READ_LATENCY - 1;

  // Reject configurations the pipeline and address decode cannot support.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("data_sram_responder: READ_LATENCY must be in 1..4");
  end
  if (ADDR_WIDTH > 30) begin : g_bad_width
    $error("data_sram_responder: ADDR_WIDTH must not exceed 30");
  end

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] index;
  logic                  out_of_range;
  logic                  is_load;
  logic                  write_en;
  logic [31:0]           sample;

  // Byte offset within a word carries no meaning for a word memory.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^data_address[1:0];

  assign index = data_address[ADDR_WIDTH+1:2];

  // With a 30-bit index every byte address maps to a real word, so there
  // are no upper bits left to check.
  if (ADDR_WIDTH < 30) begin : g_range_check
    assign out_of_range = |data_address[31:ADDR_WIDTH+2];
  end else begin : g_full_range
    assign out_of_range = 1'b0;
  end

  assign is_load  = data_enabled & (data_write_enabled == 4'b0000);
  assign write_en = data_enabled & ~reset & ~out_of_range & (|data_write_enabled);

  // The read is taken combinationally from the current contents, so it sees
  // the word as it was before this edge's write lands.
  assign sample = out_of_range ? 32'h0 : mem[index];

  // Memory contents are deliberately not reset; the reset cycle only
  // suppresses a write through write_en.
  always_ff @(posedge clock) begin
    if (write_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (data_write_enabled[lane]) begin
          mem[index][8*lane +: 8] <= data_write_data[8*lane +: 8];
        end
      end
    end
  end

  // Return pipeline. feed_* is the input to each stage: stage 0 takes the
  // access being accepted, later stages take the previous stage.
  logic [READ_LATENCY-1:0] stage_valid;
  logic [READ_LATENCY-1:0] stage_load;
  logic [31:0]             stage_data [READ_LATENCY];

  logic [READ_LATENCY-1:0] feed_valid;
  logic [READ_LATENCY-1:0] feed_load;
  logic [31:0]             feed_data [READ_LATENCY];

  always_comb begin
    feed_valid   = '0;
    feed_load    = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      feed_data[i] = 32'h0;
    end
    feed_valid[0] = data_enabled;
    feed_load[0]  = is_load;
    feed_data[0]  = sample;
    for (int i = 1; i < READ_LATENCY; i++) begin
      feed_valid[i] = stage_valid[i-1];
      feed_load[i]  = stage_load[i-1];
      feed_data[i]  = stage_data[i-1];
    end
  end

  // The last stage doubles as the output register: its data only moves when
  // a real access arrives, so idle bubbles leave data_read_data unchanged.
  // Only that register is cleared by reset; inner data is qualified by its
  // valid bit and needs no reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_valid      <= '0;
      stage_load       <= '0;
      stage_data[LAST] <= 32'h0;
      address_error    <= 1'b0;
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_valid[i] <= feed_valid[i];
        stage_load[i]  <= feed_valid[i] & feed_load[i];
        if (i < LAST || feed_valid[i]) begin
          stage_data[i] <= feed_data[i];
        end
      end
      if (data_enabled && out_of_range) begin
        address_error <= 1'b1;
      end
    end
  end

  assign data_read_data  = stage_data[LAST];
  assign data_read_valid = stage_valid[LAST] & stage_load[LAST];

`ifdef DATA_SRAM_STATS_EN
  // Activity counters; out-of-range loads still count as loads, while
  // out-of-range stores only count as errors since they are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_count  <= 32'h0;
      store_count <= 32'h0;
      error_count <= 16'h0;
    end else begin
      if (is_load) begin
        load_count <= load_count + 32'd1;
      end
      if (data_enabled && !out_of_range && (|data_write_enabled)) begin
        store_count <= store_count + 32'd1;
      end
      if (data_enabled && out_of_range) begin
        error_count <= error_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
//
// Drives one shared stimulus stream into three responders built with
// READ_LATENCY 1, 2 and 3 (ADDR_WIDTH 10). The memories therefore hold the
// same contents and each instance is checked at its own return latency
// against hand-computed values.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        data_enabled;
  logic [3:0]  data_write_enabled;
  logic [31:0] data_address;
  logic [31:0] data_write_data;

  logic [31:0] rd1, rd2, rd3;
  logic        rv1, rv2, rv3;
  logic        err1, err2, err3;

`ifdef DATA_SRAM_STATS_EN
  logic [31:0] lc1, lc2, lc3;
  logic [31:0] sc1, sc2, sc3;
  logic [15:0] ec1, ec2, ec3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  data_sram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .data_enabled(data_enabled),
    .data_write_enabled(data_write_enabled), .data_address(data_address),
    .data_write_data(data_write_data), .data_read_data(rd1),
    .data_read_valid(rv1), .address_error(err1)
`ifdef DATA_SRAM_STATS_EN
    , .load_count(lc1), .store_count(sc1), .error_count(ec1)
`endif
  );

  data_sram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .data_enabled(data_enabled),
    .data_write_enabled(data_write_enabled), .data_address(data_address),
    .data_write_data(data_write_data), .data_read_data(rd2),
    .data_read_valid(rv2), .address_error(err2)
`ifdef DATA_SRAM_STATS_EN
    , .load_count(lc2), .store_count(sc2), .error_count(ec2)
`endif
  );

  data_sram_responder #(.ADDR_WIDTH(10), .READ_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .data_enabled(data_enabled),
    .data_write_enabled(data_write_enabled), .data_address(data_address),
    .data_write_data(data_write_data), .data_read_data(rd3),
    .data_read_valid(rv3), .address_error(err3)
`ifdef DATA_SRAM_STATS_EN
    , .load_count(lc3), .store_count(sc3), .error_count(ec3)
`endif
  );

  // Present one access, let it be taken at the next rising edge and return
  // 1 time unit later so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic en, input logic [3:0] we,
                               input logic [31:0] addr, input logic [31:0] wd);
    data_enabled       = en;
    data_write_enabled = we;
    data_address       = addr;
    data_write_data    = wd;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    reset              = 1'b1;
    data_enabled       = 1'b0;
    data_write_enabled = 4'h0;
    data_address       = 32'h0;
    data_write_data    = 32'h0;

    // Reset state
    idle();
    idle();
    checkOutput("rst_rd1", rd1, 32'h0);
    checkOutput("rst_rv1", {31'h0, rv1}, 32'h0);
    checkOutput("rst_err1", {31'h0, err1}, 32'h0);
    checkOutput("rst_rd3", rd3, 32'h0);
    checkOutput("rst_rv3", {31'h0, rv3}, 32'h0);
    reset = 1'b0;
    idle();
    idle();

    // Full-word store then load
    applyStimulus(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    checkOutput("t1_store_rv1", {31'h0, rv1}, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h40, 32'h0);
    checkOutput("t1_load_rd1", rd1, 32'hDEADBEEF);
    checkOutput("t1_load_rv1", {31'h0, rv1}, 32'h1);
    idle();
    checkOutput("t1_bubble_rv1", {31'h0, rv1}, 32'h0);
    checkOutput("t1_hold_rd1", rd1, 32'hDEADBEEF);
    checkOutput("t1_l2_rd", rd2, 32'hDEADBEEF);
    checkOutput("t1_l2_rv", {31'h0, rv2}, 32'h1);
    idle();
    checkOutput("t1_l2_rv_end", {31'h0, rv2}, 32'h0);
    checkOutput("t1_l3_rd", rd3, 32'hDEADBEEF);
    checkOutput("t1_l3_rv", {31'h0, rv3}, 32'h1);

    // Byte-lane merge
    applyStimulus(1'b1, 4'hF, 32'h10, 32'h11223344);
    applyStimulus(1'b1, 4'b0101, 32'h10, 32'hAABBCCDD);
    checkOutput("t2_store_old_rd1", rd1, 32'h11223344);
    checkOutput("t2_store_rv1", {31'h0, rv1}, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h10, 32'h0);
    checkOutput("t2_merge_rd1", rd1, 32'h11BB33DD);
    checkOutput("t2_merge_rv1", {31'h0, rv1}, 32'h1);

    // Streaming with read-before-write on the latency-3 instance
    applyStimulus(1'b1, 4'hF, 32'h0, 32'hA0A0A0A0);
    applyStimulus(1'b1, 4'hF, 32'h4, 32'hB1B1B1B1);
    applyStimulus(1'b1, 4'hF, 32'h8, 32'hC2C2C2C2);
    idle();
    idle();
    applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
    checkOutput("t3_s1_rv3", {31'h0, rv3}, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h4, 32'h0);
    checkOutput("t3_s2_rv3", {31'h0, rv3}, 32'h0);
    applyStimulus(1'b1, 4'hF, 32'h0, 32'h99999999);
    checkOutput("t3_r1_rd3", rd3, 32'hA0A0A0A0);
    checkOutput("t3_r1_rv3", {31'h0, rv3}, 32'h1);
    applyStimulus(1'b1, 4'h0, 32'h8, 32'h0);
    checkOutput("t3_r2_rd3", rd3, 32'hB1B1B1B1);
    checkOutput("t3_r2_rv3", {31'h0, rv3}, 32'h1);
    applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
    checkOutput("t3_st_old_rd3", rd3, 32'hA0A0A0A0);
    checkOutput("t3_st_rv3", {31'h0, rv3}, 32'h0);
    checkOutput("t3_new_rd1", rd1, 32'h99999999);
    idle();
    checkOutput("t3_r3_rd3", rd3, 32'hC2C2C2C2);
    checkOutput("t3_r3_rv3", {31'h0, rv3}, 32'h1);
    idle();
    checkOutput("t3_r4_rd3", rd3, 32'h99999999);
    checkOutput("t3_r4_rv3", {31'h0, rv3}, 32'h1);
    idle();
    checkOutput("t3_end_rv3", {31'h0, rv3}, 32'h0);
    checkOutput("t3_end_rd3", rd3, 32'h99999999);

    // Out-of-range store and load
    checkOutput("t4_pre_err1", {31'h0, err1}, 32'h0);
    applyStimulus(1'b1, 4'hF, 32'h00001000, 32'h12345678);
    checkOutput("t4_err1_set", {31'h0, err1}, 32'h1);
    applyStimulus(1'b1, 4'h0, 32'h00001000, 32'h0);
    checkOutput("t4_oor_rd1", rd1, 32'h0);
    checkOutput("t4_oor_rv1", {31'h0, rv1}, 32'h1);
    applyStimulus(1'b1, 4'h0, 32'h0, 32'h0);
    checkOutput("t4_mem0_rd1", rd1, 32'h99999999);
    idle();
    idle();
    checkOutput("t4_err1_held", {31'h0, err1}, 32'h1);
    checkOutput("t4_err3_held", {31'h0, err3}, 32'h1);

    // Reset while loads are in flight
    applyStimulus(1'b1, 4'hF, 32'h20, 32'h5A5A5A5A);
    applyStimulus(1'b1, 4'hF, 32'h24, 32'h01020304);
    idle();
    idle();
    applyStimulus(1'b1, 4'h0, 32'h20, 32'h0);
    checkOutput("t5_pre_rd1", rd1, 32'h5A5A5A5A);
    reset = 1'b1;
    applyStimulus(1'b1, 4'hF, 32'h24, 32'hFFFFFFFF);
    checkOutput("t5_rst_rv2", {31'h0, rv2}, 32'h0);
    checkOutput("t5_rst_rd2", rd2, 32'h0);
    checkOutput("t5_rst_rv3", {31'h0, rv3}, 32'h0);
    checkOutput("t5_rst_rd3", rd3, 32'h0);
    checkOutput("t5_rst_rd1", rd1, 32'h0);
    checkOutput("t5_rst_err1", {31'h0, err1}, 32'h0);
    checkOutput("t5_rst_err3", {31'h0, err3}, 32'h0);
    reset = 1'b0;
    idle();
    checkOutput("t5_post1_rv2", {31'h0, rv2}, 32'h0);
    checkOutput("t5_post1_rv3", {31'h0, rv3}, 32'h0);
    idle();
    checkOutput("t5_post2_rv3", {31'h0, rv3}, 32'h0);
    checkOutput("t5_post2_rd3", rd3, 32'h0);
    applyStimulus(1'b1, 4'h0, 32'h20, 32'h0);
    checkOutput("t5_kept_rd1", rd1, 32'h5A5A5A5A);
    checkOutput("t5_kept_rv1", {31'h0, rv1}, 32'h1);
    applyStimulus(1'b1, 4'h0, 32'h24, 32'h0);
    checkOutput("t5_nowrite_rd1", rd1, 32'h01020304);
    checkOutput("t5_err1_clear", {31'h0, err1}, 32'h0);

    // Single top-lane strobe
    applyStimulus(1'b1, 4'b1000, 32'h24, 32'hEE000000);
    applyStimulus(1'b1, 4'h0, 32'h24, 32'h0);
    checkOutput("t6_lane3_rd1", rd1, 32'hEE020304);

`ifdef DATA_SRAM_STATS_EN
    // Counters: 3 stores, 5 loads, 1 out-of-range load
    reset = 1'b1;
    idle();
    reset = 1'b0;
    applyStimulus(1'b1, 4'hF, 32'h100, 32'h1);
    applyStimulus(1'b1, 4'hF, 32'h104, 32'h2);
    applyStimulus(1'b1, 4'hF, 32'h108, 32'h3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'h0, 32'h100 + 32'(4 * (i % 3)), 32'h0);
    end
    applyStimulus(1'b1, 4'h0, 32'h2000, 32'h0);
    idle();
    checkOutput("st_load_count", lc1, 32'd6);
    checkOutput("st_store_count", sc1, 32'd3);
    checkOutput("st_error_count", {16'h0, ec1}, 32'd1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checkOutput("st_load_rst", lc1, 32'd0);
    checkOutput("st_store_rst", sc1, 32'd0);
    checkOutput("st_error_rst", {16'h0, ec1}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
